// File: rtl/decodificador_timer_pkg.sv
// Shared types and constants for the microwave countdown timer: state encoding,
// BCD time layout, 7-segment patterns and the BCD decrement helper.
package decodificador_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        digit_t min_t;
        digit_t min_u;
        digit_t sec_t;
        digit_t sec_u;
    } time_t;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // One-second BCD decrement; seconds tens wrap to 5, every other digit to 9.
    function automatic time_t bcd_dec(input time_t t);
        time_t r;
        r = t;
        if (t.sec_u != 4'd0) begin
            r.sec_u = t.sec_u - 4'd1;
        end else begin
            r.sec_u = 4'd9;
            if (t.sec_t != 4'd0) begin
                r.sec_t = t.sec_t - 4'd1;
            end else begin
                r.sec_t = 4'd5;
                if (t.min_u != 4'd0) begin
                    r.min_u = t.min_u - 4'd1;
                end else begin
                    r.min_u = 4'd9;
                    r.min_t = t.min_t - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decodificador_timer_bcd_seg7.sv
// Combinational BCD to 7-segment decoder, zero latency; codes 10-15 decode to blank
// so the caller can force a blank digit by presenting 4'hF.
module bcd_seg7
    import decodificador_timer_pkg::*;
(
    input  digit_t     bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decodificador_timer.sv
// MM:SS keypad entry, 1 Hz countdown and 4-digit display scan; outputs registered, one-cycle update,
// no backpressure (inputs are strobes). LEADING_ZERO_BLANK_EN blanks leading zero minute digits.
module decodificador_timer
    import decodificador_timer_pkg::*;
#(
    parameter int SCAN_DIV  = 1,
    parameter int DONE_HOLD = 3
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [3:0]   digit_in,
    input  logic         digit_valid,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         tick_1hz,
    output logic [3:0]   min_t,
    output logic [3:0]   min_u,
    output logic [3:0]   sec_t,
    output logic [3:0]   sec_u,
    output logic         running,
    output logic         done,
    output logic [6:0]   seg,
    output logic [3:0]   an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD + 1) : 1;

    state_t              state, state_nxt;
    time_t               tm, tm_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          scan_idx, scan_idx_nxt;
    digit_t              disp_digit;
    logic                time_zero;

    assign time_zero = (tm == '0);

    // Event priority: clear > stop > tick_1hz > start > digit_valid.
    always_comb begin
        state_nxt = state;
        tm_nxt    = tm;
        hold_nxt  = hold_cnt;
        if (clear) begin
            state_nxt = ST_IDLE;
            tm_nxt    = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !time_zero) begin
                        state_nxt = ST_RUN;
                        if (tm.sec_t > 4'd5) begin
                            tm_nxt.sec_t = 4'd5;
                            tm_nxt.sec_u = 4'd9;
                        end
                    end else if (digit_valid && (digit_in <= 4'd9)) begin
                        tm_nxt = {tm.min_u, tm.sec_t, tm.sec_u, digit_in};
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_PAUSE;
                    end else if (tick_1hz) begin
                        tm_nxt = bcd_dec(tm);
                        if (tm_nxt == '0) begin
                            state_nxt = ST_DONE;
                            hold_nxt  = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (tick_1hz) begin
                        if (hold_cnt == HOLD_W'(DONE_HOLD - 1)) begin
                            state_nxt = ST_IDLE;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tm       <= '0;
            hold_cnt <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tm       <= tm_nxt;
            hold_cnt <= hold_nxt;
            running  <= (state_nxt == ST_RUN);
            done     <= (state_nxt == ST_DONE);
        end
    end

    assign scan_idx_nxt = scan_idx + 2'd1;

    // an is kept as its own register so it changes on the same edge as scan_idx.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            an       <= 4'b1110;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx_nxt;
            an       <= ~(4'b0001 << scan_idx_nxt);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        case (scan_idx)
            2'd0:    disp_digit = tm.sec_u;
            2'd1:    disp_digit = tm.sec_t;
            2'd2:    disp_digit = tm.min_u;
            default: disp_digit = tm.min_t;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (((scan_idx == 2'd3) && (tm.min_t == 4'd0)) ||
            ((scan_idx == 2'd2) && (tm.min_t == 4'd0) && (tm.min_u == 4'd0))) begin
            disp_digit = 4'hF;
        end
`endif
    end

    bcd_seg7 u_bcd_seg7 (
        .bcd (disp_digit),
        .seg (seg)
    );

    assign min_t = tm.min_t;
    assign min_u = tm.min_u;
    assign sec_t = tm.sec_t;
    assign sec_u = tm.sec_u;

endmodule

// File: tb/tb_decodificador_timer.sv
// Random and directed stimulus against a seconds-based reference model; expected
// outputs are queued per clock edge and compared by an independent monitor.
module tb_decodificador_timer;

    localparam int SCAN_DIV  = 2;
    localparam int DONE_HOLD = 3;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, done;
    logic [6:0] seg;
    logic [3:0] an;

    decodificador_timer #(.SCAN_DIV(SCAN_DIV), .DONE_HOLD(DONE_HOLD)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .tick_1hz    (tick_1hz),
        .min_t       (min_t),
        .min_u       (min_u),
        .sec_t       (sec_t),
        .sec_u       (sec_u),
        .running     (running),
        .done        (done),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] tm;
        logic        running;
        logic        done;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;

    // Model: digits as plain integers, countdown done in total seconds.
    int         m_d[4];
    mstate_t    m_st;
    int         m_hold;
    int         m_edges;
    logic [6:0] seg_tab[10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    function automatic int m_total();
        return (m_d[0] * 10 + m_d[1]) * 60 + m_d[2] * 10 + m_d[3];
    endfunction

    function automatic void set_total(input int t);
        m_d[0] = t / 600;
        m_d[1] = (t / 60) % 10;
        m_d[2] = (t % 60) / 10;
        m_d[3] = t % 10;
    endfunction

    function automatic void model_reset();
        m_d    = '{0, 0, 0, 0};
        m_st   = M_IDLE;
        m_hold = 0;
        m_edges = 0;
    endfunction

    function automatic void model_edge();
        if (clear) begin
            m_st = M_IDLE;
            m_d  = '{0, 0, 0, 0};
            m_hold = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (start && m_total() != 0) begin
                        if (m_d[2] > 5) begin
                            m_d[2] = 5;
                            m_d[3] = 9;
                        end
                        m_st = M_RUN;
                    end else if (digit_valid && digit_in <= 4'd9) begin
                        m_d[0] = m_d[1];
                        m_d[1] = m_d[2];
                        m_d[2] = m_d[3];
                        m_d[3] = int'(digit_in);
                    end
                end
                M_RUN: begin
                    if (stop) m_st = M_PAUSE;
                    else if (tick_1hz) begin
                        set_total(m_total() - 1);
                        if (m_total() == 0) begin
                            m_st = M_DONE;
                            m_hold = 0;
                        end
                    end
                end
                M_PAUSE: if (start && !stop) m_st = M_RUN;
                M_DONE: begin
                    if (tick_1hz) begin
                        m_hold++;
                        if (m_hold == DONE_HOLD) begin
                            m_st = M_IDLE;
                            m_hold = 0;
                        end
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
        m_edges++;
    endfunction

    function automatic exp_t expected();
        exp_t       e;
        int         idx;
        int         dig;
        bit         blank;
        logic [3:0] one;
        one   = 4'b0001;
        idx   = (m_edges / SCAN_DIV) % 4;
        dig   = m_d[3 - idx];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx == 3 && m_d[0] == 0) || (idx == 2 && m_d[0] == 0 && m_d[1] == 0);
`endif
        e.tm      = {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
        e.running = (m_st == M_RUN);
        e.done    = (m_st == M_DONE);
        e.an      = ~(one << idx);
        e.seg     = blank ? 7'h00 : seg_tab[dig];
        return e;
    endfunction

    always @(negedge clk_in) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({min_t, min_u, sec_t, sec_u} !== mon_e.tm || running !== mon_e.running ||
                done !== mon_e.done || an !== mon_e.an || seg !== mon_e.seg) begin
                errors++;
                $display("FAIL scoreboard @%0t: got time=%h run=%b done=%b an=%b seg=%b, expected time=%h run=%b done=%b an=%b seg=%b",
                         $time, {min_t, min_u, sec_t, sec_u}, running, done, an, seg,
                         mon_e.tm, mon_e.running, mon_e.done, mon_e.an, mon_e.seg);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cur_time();
        return int'({min_t, min_u, sec_t, sec_u});
    endfunction

    task automatic cyc(input bit s, input bit sp, input bit cl, input bit tk,
                       input bit dv, input logic [3:0] d);
        start = s; stop = sp; clear = cl; tick_1hz = tk; digit_valid = dv; digit_in = d;
        @(posedge clk_in);
        #1;
        model_edge();
        sb_q.push_back(expected());
    endtask

    task automatic key(input logic [3:0] d);
        cyc(0, 0, 0, 0, 1, d);
    endtask

    task automatic tick();
        cyc(0, 0, 0, 1, 0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic check_reset();
        chk("reset_time", cur_time(), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_an", int'(an), 'hE);
        chk("reset_seg", int'(seg), 'h7E);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset();
        @(negedge clk_in);
        rst_n = 1'b1;

        // Entry, overflow of the oldest digit, and an ignored non-BCD code
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("entry_1234", cur_time(), 'h1234);
        key(4'd5);
        chk("entry_shift", cur_time(), 'h2345);
        key(4'd12);
        chk("entry_ignore12", cur_time(), 'h2345);

        // Display scan at 12:34
        cyc(0, 0, 1, 0, 0, 4'd0);
        chk("clear_idle", cur_time(), 0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        idle(10);

        // Seconds clamp and borrows down to DONE, then DONE_HOLD ticks
        cyc(0, 0, 1, 0, 0, 4'd0);
        key(4'd0); key(4'd1); key(4'd7); key(4'd0);
        chk("entry_0170", cur_time(), 'h0170);
        cyc(1, 0, 0, 0, 0, 4'd0);
        chk("clamp_0159", cur_time(), 'h0159);
        chk("clamp_running", int'(running), 1);
        repeat (60) tick();
        chk("borrow_0059", cur_time(), 'h0059);
        repeat (57) tick();
        chk("count_0002", cur_time(), 'h0002);
        tick();
        chk("count_done_early", int'(done), 0);
        tick();
        chk("done_time", cur_time(), 0);
        chk("done_rise", int'(done), 1);
        chk("done_running_fall", int'(running), 0);
        tick(); tick();
        chk("done_hold", int'(done), 1);
        tick();
        chk("done_fall", int'(done), 0);
        idle(2);

        // Priority of stop over tick, and pause freezing the time
        cyc(0, 0, 1, 0, 0, 4'd0);
        key(4'd1); key(4'd0);
        cyc(1, 0, 0, 0, 0, 4'd0);
        cyc(0, 1, 0, 1, 0, 4'd0);
        chk("pause_time", cur_time(), 'h0010);
        chk("pause_running", int'(running), 0);
        repeat (3) tick();
        key(4'd7);
        chk("pause_frozen", cur_time(), 'h0010);
        cyc(1, 0, 0, 0, 0, 4'd0);
        tick();
        chk("resume_0009", cur_time(), 'h0009);

        // Clear while running
        cyc(0, 0, 1, 0, 0, 4'd0);
        key(4'd5); key(4'd0); key(4'd0);
        cyc(1, 0, 0, 0, 0, 4'd0);
        cyc(0, 0, 1, 0, 0, 4'd0);
        chk("clear_run_time", cur_time(), 0);
        chk("clear_run_running", int'(running), 0);

        // Asynchronous reset mid-countdown
        key(4'd3); key(4'd0);
        cyc(1, 0, 0, 0, 0, 4'd0);
        tick(); tick(); idle(1);
        @(negedge clk_in);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();

        // Leading zeros at 00:07
        key(4'd0); key(4'd7);
        idle(10);

        // Random traffic
        repeat (2000) begin
            cyc(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 64) == 0,
                ($urandom % 4) == 0, ($urandom % 3) == 0, 4'($urandom_range(0, 15)));
        end

        idle(1);
        @(negedge clk_in);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decodificador_timer.md
# decodificador_timer

Consumer-side counterpart of the keypad input encoder. It accepts the encoder's BCD digit strobes, assembles them into an MM:SS cooking time and counts the time down once per pulse of the 1 Hz enable from the clock divider. It also drives a 4-digit multiplexed 7-segment display. It sits between the input encoder and the magnetron/display outputs of the microwave.

## Interface
Parameters:
- SCAN_DIV, 1: number of clk_in cycles each display digit stays selected before the scan advances.
- DONE_HOLD, 3: number of tick_1hz pulses that done stays asserted before the block returns to IDLE.

Ports:
- clk_in, input, 1: single system clock. All state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- digit_in, input, 4: BCD digit from the encoder.
- digit_valid, input, 1: one-cycle strobe qualifying digit_in.
- start, input, 1: begin or resume the countdown. Level sampled on each edge.
- stop, input, 1: pause the countdown.
- clear, input, 1: abort and zero the time.
- tick_1hz, input, 1: one-cycle enable pulse from the clock divider.
- min_t, min_u, sec_t, sec_u, output, 4 each: current BCD time.
- running, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- seg, output, 7: segments a–g, active-high.
- an, output, 4: digit enables, active-low; an[3] is min_t.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset value is IDLE.
- Reset values: all time digits 0, running=0, done=0, an=4'b1110, scan index 0, scan counter 0.
- IDLE, digit entry:
  - digit_valid with digit_in ≤ 9 shifts the time left one digit: min_t←min_u, min_u←sec_t, sec_t←sec_u, sec_u←digit_in. The old min_t is lost.
  - Digits 10–15 are ignored.
- IDLE, start:
  - If the time is 00:00, start is ignored.
  - Otherwise go to RUN. If sec_t>5, the seconds field is clamped to 59 on that same edge.
- RUN:
  - Each tick_1hz performs a BCD decrement.
  - sec_u wraps 0→9 with a borrow from sec_t; sec_t wraps 0→5 with a borrow from min_u; min_u wraps 0→9 with a borrow from min_t.
  - A decrement that produces 00:00 moves to DONE on the same edge.
  - stop moves to PAUSE.
- PAUSE: the time is frozen. start returns to RUN. digit_valid is ignored.
- DONE:
  - The time stays 00:00.
  - The block counts DONE_HOLD tick_1hz pulses, then goes to IDLE.
  - start and digit_valid are ignored.
- clear, from any state: go to IDLE and zero all digits.
- Priority when events coincide: clear > stop > tick_1hz > start > digit_valid.
  - Example: stop and tick_1hz on the same edge in RUN → PAUSE with no decrement.
- Display scan:
  - The scan counter runs continuously in every state.
  - The digit select rotates sec_u → sec_t → min_u → min_t, changing every SCAN_DIV cycles.
  - seg carries the standard 7-segment decode of the selected digit. an is one-hot-low on the selected digit.

## Timing
- All outputs are registered, except seg, which is combinational from the registered select and the registered digits.
- A digit strobe is visible on sec_u one cycle after the digit_valid edge.
- A decrement is visible on the outputs on the edge that samples tick_1hz=1.
- Countdown 00:01 → 00:00: running falls and done rises on the same edge.
- done stays high until the edge that samples the DONE_HOLD-th tick in DONE.
- An asynchronous rst_n assertion mid-countdown forces all reset values immediately. Operation resumes from IDLE on the first edge after release.
- Maximum time 99:59. No other overflow path exists.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - When the display selects min_t=0, or selects min_u=0 while min_t=0, seg is driven to 7'b0000000. an still selects that digit.
  - sec_t and sec_u are never blanked.
- LEADING_ZERO_BLANK_EN not defined: every digit is always displayed, including zeros.

## Structure
- Shared package contents:
  - State encoding constants (IDLE/RUN/PAUSE/DONE).
  - The 7-segment pattern constants for 0–9.
  - The blank pattern.
  - The BCD digit width (4).
- Sub-module: bcd_seg7, a combinational BCD-to-segment decoder instantiated once on the scan-selected digit. Codes 10–15 decode to blank.

## Test plan
- Entry: strobe 1,2,3,4 → 12:34. Strobe a fifth digit 5 → 23:45. Strobe 12 → time unchanged.
- Clamp and borrow: enter 0,1,7,0, then start → 01:59. Apply 60 ticks → 00:59, then 00:58 … 00:00.
- Done: from 00:02 in RUN, apply 2 ticks → done=1 and running=0 on the 2nd tick. done falls on the 3rd tick after that (DONE_HOLD=3), then state is IDLE.
- Priority and pause: in RUN at 00:10, stop and tick_1hz on the same edge → PAUSE at 00:10. Ticks while paused → no change. start → RUN, next tick → 00:09.
- Clear and reset: clear in RUN at 05:00 → IDLE with 00:00 next edge. Assert rst_n low mid-run → all outputs at reset values with no clock edge.
- Scan (SCAN_DIV=2) at 12:34: an sequence 1110, 1101, 1011, 0111, each held 2 cycles, with seg = 4,3,2,1 patterns. With LEADING_ZERO_BLANK_EN at 00:07: seg blank while an=0111 and while an=1011.
